max_int16_stream: RTL and testbench

- Streaming signed-integer max reducer that pairs with the combinational 16-bit min datapath. It scans a frame of WIDTH-bit two's-complement values and returns the largest value and the position of its first occurrence.
- Comparison is bit-serial, MSB-first, one bit per cycle, matching the PIM bit-serial evaluation model.
- Sits between an upstream element stream and a result consumer. Both sides use valid/ready handshakes.

---
 rtl/max_int16_stream.sv | 171 +++++++++++++++++
 tb/tb_max_int16_stream.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/max_int16_stream.sv
// Streaming signed max reducer: scans a frame of two's-complement elements and reports
// the largest value plus the index of its first occurrence, comparing bit-serially MSB first.
module max_int16_stream #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned IDX_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] max_out,
   output logic [IDX_W-1:0] idx_out
);

   localparam int unsigned PTR_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPARE = 2'd1,
      DONE    = 2'd2
   } state_t;

   state_t state, state_nx;

   logic             first_q;
   logic [IDX_W-1:0] cnt_q;
   logic [WIDTH-1:0] max_q;
   logic [IDX_W-1:0] idx_q;
   logic [WIDTH-1:0] cand_q;
   logic [IDX_W-1:0] cand_idx_q;
   logic             cand_last_q;
   logic [PTR_W-1:0] ptr_q;
   logic             decided_q;
   logic             gt_q;

   logic             accept_c;
   logic             cand_bit_c;
   logic             max_bit_c;
   logic             differ_c;
   logic             sign_bit_c;
   logic             gt_bit_c;
   logic             gt_final_c;
   logic             ptr_zero_c;
   logic             load_result_c;
   logic             release_c;
   logic [WIDTH-1:0] new_max_c;
   logic [IDX_W-1:0] new_idx_c;

   // in_ready is a pure state decode, forced low while reset is held
   assign in_ready  = rst_n && (state == IDLE);
   assign accept_c  = in_valid && in_ready;
   assign release_c = (state == DONE) && out_ready;

   // Bit-serial compare of the candidate against the running maximum.
   // At the sign bit a 0 marks the larger value, at magnitude bits a 1 does.
   assign cand_bit_c = cand_q[ptr_q];
   assign max_bit_c  = max_q[ptr_q];
   assign differ_c   = cand_bit_c ^ max_bit_c;
   assign sign_bit_c = (ptr_q == PTR_W'(WIDTH - 1));
   assign gt_bit_c   = sign_bit_c ? ~cand_bit_c : cand_bit_c;
   assign gt_final_c = decided_q ? gt_q : (differ_c & gt_bit_c);
   assign ptr_zero_c = (ptr_q == '0);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next state, result-load strobe and next running max/index
   always_comb begin
      state_nx      = state;
      load_result_c = 1'b0;
      new_max_c     = max_q;
      new_idx_c     = idx_q;
      case (state)
         IDLE: begin
            if (accept_c) begin
               if (first_q) begin
                  new_max_c     = in_data;
                  new_idx_c     = cnt_q;
                  load_result_c = in_last;
                  state_nx      = in_last ? DONE : IDLE;
               end else begin
                  state_nx = COMPARE;
               end
            end
         end
         COMPARE: begin
            if (ptr_zero_c) begin
               if (gt_final_c) begin
                  new_max_c = cand_q;
                  new_idx_c = cand_idx_q;
               end
               load_result_c = cand_last_q;
               state_nx      = cand_last_q ? DONE : IDLE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_nx = IDLE;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // Running max, published result and handshake flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         max_q     <= '0;
         idx_q     <= '0;
         max_out   <= '0;
         idx_out   <= '0;
         out_valid <= 1'b0;
      end else begin
         max_q     <= new_max_c;
         idx_q     <= new_idx_c;
         out_valid <= (state_nx == DONE);
         if (load_result_c) begin
            max_out <= new_max_c;
            idx_out <= new_idx_c;
         end
      end
   end

   // Candidate capture, element counter and bit-serial compare state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         first_q     <= 1'b1;
         cnt_q       <= '0;
         cand_q      <= '0;
         cand_idx_q  <= '0;
         cand_last_q <= 1'b0;
         ptr_q       <= '0;
         decided_q   <= 1'b0;
         gt_q        <= 1'b0;
      end else begin
         if (accept_c) begin
            cnt_q       <= cnt_q + IDX_W'(1);
            cand_q      <= in_data;
            cand_idx_q  <= cnt_q;
            cand_last_q <= in_last;
            first_q     <= 1'b0;
            ptr_q       <= PTR_W'(WIDTH - 1);
            decided_q   <= 1'b0;
            gt_q        <= 1'b0;
         end else if (state == COMPARE) begin
            ptr_q <= ptr_q - PTR_W'(1);
            if (!decided_q && differ_c) begin
               decided_q <= 1'b1;
               gt_q      <= gt_bit_c;
            end
         end
         if (release_c) begin
            first_q <= 1'b1;
            cnt_q   <= '0;
         end
      end
   end

endmodule

// File: tb/tb_max_int16_stream.sv
// Randomised and directed bench for max_int16_stream against a frame-level max/argmax model.
module tb_max_int16_stream;

   localparam int unsigned WIDTH = 16;
   localparam int unsigned IDX_W = 8;

   typedef struct {
      logic [WIDTH-1:0] m;
      logic [IDX_W-1:0] i;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] max_out;
   logic [IDX_W-1:0] idx_out;

   int checks = 0;
   int errors = 0;
   int ready_mode = 0;   // 0: always ready, 1: random, 2: stalled

   logic [WIDTH-1:0] frame[$];
   exp_t             exp_q[$];
   int               waits[0:511];

   max_int16_stream #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_last  (in_last),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .max_out  (max_out),
      .idx_out  (idx_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Reference: largest signed value, earliest position, index reported modulo 2^IDX_W
   function automatic exp_t model_frame();
      exp_t r;
      int   best = 0;
      for (int k = 1; k < frame.size(); k++)
         if ($signed(frame[k]) > $signed(frame[best])) best = k;
      r.m = frame[best];
      r.i = IDX_W'(best);
      return r;
   endfunction

   // Consumer
   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
         endcase
      end
   end

   // Result compare against queued model results
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_result: max_out %h idx_out %h with no frame pending", max_out, idx_out);
         end else begin
            chk("result_max", 32'(max_out), 32'(exp_q[0].m));
            chk("result_idx", 32'(idx_out), 32'(exp_q[0].i));
            if (out_ready) void'(exp_q.pop_front());
         end
      end
   end

   task automatic send(input logic [WIDTH-1:0] d, input logic last, output int waited);
      bit got = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      waited   = 0;
      while (!got) begin
         @(negedge clk);
         if (in_ready) begin
            got = 1;
         end else begin
            waited++;
            if (waited > 200) begin
               checks++;
               errors++;
               $display("FAIL accept_timeout: in_ready stuck low for %0d cycles", waited);
               got = 1;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input bit keep);
      int w;
      exp_q.push_back(model_frame());
      for (int k = 0; k < frame.size(); k++) begin
         send(frame[k], k == frame.size() - 1, w);
         if (k < 512) waits[k] = w;
      end
      if (!keep) in_valid = 1'b0;
   endtask

   task automatic wait_result();
      int n = 0;
      while (exp_q.size() > 0 && n < 3000) begin
         @(posedge clk);
         n++;
      end
      if (exp_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL result_timeout: %0d results outstanding", exp_q.size());
         exp_q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      exp_t e;
      int   w;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      in_last  = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_in_ready", 32'(in_ready), 32'd0);
      chk("reset_max_out", 32'(max_out), 32'd0);
      chk("reset_idx_out", 32'(idx_out), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;

      // Single most-negative element: result the cycle after acceptance
      frame = '{16'h8000};
      send_frame(0);
      @(negedge clk);
      chk("single_out_valid", 32'(out_valid), 32'd1);
      chk("single_max", 32'(max_out), 32'h8000);
      chk("single_idx", 32'(idx_out), 32'd0);
      wait_result();

      // Ties: first 7 wins; WIDTH low cycles after each non-first acceptance
      frame = '{16'd5, 16'hFFFD, 16'd7, 16'd7, 16'd2};
      e = model_frame();
      chk("pin_tie_max", 32'(e.m), 32'd7);
      chk("pin_tie_idx", 32'(e.i), 32'd2);
      send_frame(0);
      chk("gap_after_first", 32'(waits[1]), 32'd0);
      for (int k = 2; k < 5; k++) chk("gap_after_compare", 32'(waits[k]), 32'(WIDTH));
      wait_result();

      frame = '{16'hFFFF, 16'h0000, 16'h8000, 16'h7FFF};
      e = model_frame();
      chk("pin_sign_max", 32'(e.m), 32'h7FFF);
      chk("pin_sign_idx", 32'(e.i), 32'd3);
      send_frame(0);
      wait_result();

      frame = '{16'hFFFB, 16'hFFFE, 16'hFFF7};
      e = model_frame();
      chk("pin_neg_max", 32'(e.m), 32'hFFFE);
      chk("pin_neg_idx", 32'(e.i), 32'd1);
      send_frame(0);
      wait_result();

      // Backpressure: result and handshake frozen while the consumer stalls
      ready_mode = 2;
      frame = '{16'd100, 16'hFFCE, 16'd100};
      send_frame(0);
      w = 0;
      while (!out_valid && w < 100) begin
         @(negedge clk);
         w++;
      end
      chk("bp_reached_done", 32'(out_valid), 32'd1);
      repeat (10) begin
         @(negedge clk);
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_max", 32'(max_out), 32'd100);
         chk("bp_idx", 32'(idx_out), 32'd0);
      end
      ready_mode = 0;
      wait_result();
      frame = '{16'd4};
      send_frame(0);
      wait_result();

      // Reset in the middle of a compare discards the frame
      frame = '{16'd1, 16'd9};
      for (int k = 0; k < 2; k++) send(frame[k], k == 1, w);
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      exp_q.delete();
      repeat (3) begin
         @(negedge clk);
         chk("midreset_out_valid", 32'(out_valid), 32'd0);
         chk("midreset_in_ready", 32'(in_ready), 32'd0);
      end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      frame = '{16'd3};
      send_frame(0);
      wait_result();
      chk("post_reset_max", 32'(max_out), 32'd3);
      chk("post_reset_idx", 32'(idx_out), 32'd0);

      // Back-to-back frames with in_valid held high
      frame = '{16'd10, 16'd20};
      send_frame(1);
      frame = '{16'hFFFF};
      send_frame(0);
      wait_result();

      // Randomised frames with random backpressure
      ready_mode = 1;
      for (int f = 0; f < 40; f++) begin
         int len = int'($urandom_range(1, 8));
         frame.delete();
         for (int k = 0; k < len; k++) begin
            case ($urandom_range(0, 3))
               0:       frame.push_back(WIDTH'(int'($urandom_range(0, 6)) - 3));
               1:       frame.push_back(($urandom_range(0, 1) == 1) ? 16'h8000 : 16'h7FFF);
               default: frame.push_back(WIDTH'($urandom));
            endcase
         end
         send_frame(0);
         if ($urandom_range(0, 3) == 0) wait_result();
      end
      wait_result();

      // Long frame: index counter wraps, later tie does not replace the max
      ready_mode = 0;
      frame.delete();
      for (int k = 0; k < 300; k++) frame.push_back(WIDTH'(int'($urandom_range(0, 2000)) - 1000));
      frame[290] = 16'd5000;
      frame[295] = 16'd5000;
      e = model_frame();
      chk("pin_wrap_max", 32'(e.m), 32'd5000);
      chk("pin_wrap_idx", 32'(e.i), 32'd34);
      send_frame(0);
      wait_result();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
